// File: rtl/board_ram.sv
// Single-clock board-state RAM with a hardware clear sweep, registered reads,
// write-first collision handling and out-of-range address detection.
module board_ram #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_valid,
    output logic                  busy,
    output logic                  addr_error
);

    localparam int unsigned           IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastPtr   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DepthCmp  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {StClear, StIdle} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] w_dout_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_err;
    logic                  w_err_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [IdxW-1:0]       w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_data;

    logic                  w_wr_oor;
    logic                  w_rd_oor;
    logic                  w_wr_ok;
    logic [IdxW-1:0]       w_wr_idx;
    logic [IdxW-1:0]       w_rd_idx;

    // Comparison is one bit wider so DEPTH == 2**ADDR_WIDTH never flags an error.
    assign w_wr_oor = ({1'b0, write_address} >= DepthCmp);
    assign w_rd_oor = ({1'b0, read_address} >= DepthCmp);
    assign w_wr_ok  = write_enable && !w_wr_oor;
    assign w_wr_idx = write_address[IdxW-1:0];
    assign w_rd_idx = read_address[IdxW-1:0];

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_dout_next  = r_dout;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_idx    = r_ptr[IdxW-1:0];
        w_mem_data   = CLEAR_VALUE;

        unique case (r_state)
            StClear: begin
                w_mem_we = 1'b1;
                if (r_ptr == LastPtr) begin
                    w_state_next = StIdle;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            StIdle: begin
                if (clear) begin
                    w_state_next = StClear;
                    w_ptr_next   = '0;
                end else begin
                    w_mem_we   = w_wr_ok;
                    w_mem_idx  = w_wr_idx;
                    w_mem_data = d_in;
                    w_err_next = (write_enable && w_wr_oor) || (read_enable && w_rd_oor);
                    if (read_enable) begin
                        w_valid_next = 1'b1;
                        if (w_rd_oor) begin
                            w_dout_next = '0;
                        end else if (w_wr_ok && (write_address == read_address)) begin
                            w_dout_next = d_in;
                        end else begin
                            w_dout_next = r_mem[w_rd_idx];
                        end
                    end
                end
            end
            default: begin
                w_state_next = StClear;
                w_ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= StClear;
            r_ptr   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_dout  <= w_dout_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    // Array has no reset; the sweep initialises it.
    always_ff @(posedge clock) begin
        if (reset_n && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_data;
        end
    end

    assign d_out      = r_dout;
    assign d_valid    = r_valid;
    assign busy       = (r_state == StClear);
    assign addr_error = r_err;

endmodule
